// File: rtl/pipeid_stage_pkg.sv
// rtl/pipeid_stage_pkg.sv - shared constants, forward-select enum and ID/EX width helper
package pipeid_stage_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MA,
    FWD_MD
  } fwd_sel_e;

  // valid, wreg, m2reg (3) + rn (5) + ctl + a, b, imm, pc4
  function automatic int idex_width(input int xlen, input int ctlw);
    return 8 + ctlw + 4 * xlen;
  endfunction

endpackage

// File: rtl/pipeid_stage_if.sv
// rtl/pipeid_stage_if.sv - ID-stage inputs from IF/ID, decoder, EX/MEM/WB and ID/EX outputs
interface pipeid_stage_if #(
  parameter int XLEN = 32,
  parameter int CTLW = 8
);
  logic            d_valid;
  logic [31:0]     d_inst;
  logic [XLEN-1:0] d_pc4;
  logic [CTLW-1:0] d_ctl;
  logic            d_uses_rs, d_uses_rt, d_wreg, d_m2reg, d_regrt, d_sext;
  logic [1:0]      d_br;
  logic            d_flush;
  logic [XLEN-1:0] e_alu;
  logic            m_wreg, m_m2reg;
  logic [4:0]      m_rn;
  logic [XLEN-1:0] m_alu, m_mdata;
  logic            w_wreg;
  logic [4:0]      w_rn;
  logic [XLEN-1:0] w_data;

  logic            stall, br_taken;
  logic [XLEN-1:0] bpc;
  logic            e_valid, e_wreg, e_m2reg;
  logic [4:0]      e_rn;
  logic [CTLW-1:0] e_ctl;
  logic [XLEN-1:0] e_a, e_b, e_imm, e_pc4;

  modport slave (
    input  d_valid, d_inst, d_pc4, d_ctl, d_uses_rs, d_uses_rt, d_wreg, d_m2reg,
           d_regrt, d_sext, d_br, d_flush, e_alu, m_wreg, m_m2reg, m_rn, m_alu,
           m_mdata, w_wreg, w_rn, w_data,
    output stall, br_taken, bpc, e_valid, e_wreg, e_m2reg, e_rn, e_ctl,
           e_a, e_b, e_imm, e_pc4
  );

  modport master (
    output d_valid, d_inst, d_pc4, d_ctl, d_uses_rs, d_uses_rt, d_wreg, d_m2reg,
           d_regrt, d_sext, d_br, d_flush, e_alu, m_wreg, m_m2reg, m_rn, m_alu,
           m_mdata, w_wreg, w_rn, w_data,
    input  stall, br_taken, bpc, e_valid, e_wreg, e_m2reg, e_rn, e_ctl,
           e_a, e_b, e_imm, e_pc4
  );
endinterface

// File: rtl/pipeid_stage_regfile.sv
// rtl/pipeid_stage_regfile.sv - two-read one-write register file with WB write-through
module pipeid_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [4:0]      ra_i,
  input  logic [4:0]      rb_i,
  input  logic            w_we_i,
  input  logic [4:0]      w_rn_i,
  input  logic [XLEN-1:0] w_data_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);
  localparam logic [5:0] NREG_L = 6'(NREG);

  // Sized for the full 5-bit index; entries at or above NREG are never written.
  logic [XLEN-1:0] rf_q [32];
  logic            w_ok, a_ok, b_ok;

  assign w_ok = w_we_i && (w_rn_i != 5'd0) && ({1'b0, w_rn_i} < NREG_L);
  assign a_ok = (ra_i != 5'd0) && ({1'b0, ra_i} < NREG_L);
  assign b_ok = (rb_i != 5'd0) && ({1'b0, rb_i} < NREG_L);

  assign a_o = !a_ok ? '0 : (w_ok && w_rn_i == ra_i) ? w_data_i : rf_q[ra_i];
  assign b_o = !b_ok ? '0 : (w_ok && w_rn_i == rb_i) ? w_data_i : rf_q[rb_i];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (w_ok) begin
      rf_q[w_rn_i] <= w_data_i;
    end
  end
endmodule

// File: rtl/pipeid_stage.sv
// rtl/pipeid_stage.sv - decode stage: operand read/forward, load-use stall, branch resolve, ID/EX register
module pipeid_stage
  import pipeid_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CTLW = 8
) (
  input logic           clk,
  input logic           clrn,
  pipeid_stage_if.slave id
);
  localparam int IDEX_W = idex_width(XLEN, CTLW);

  logic [4:0]       rs, rt, rd, rn;
  logic [15:0]      imm16;
  logic [XLEN-1:0]  rf_a, rf_b, fwd_a, fwd_b, imm;
  fwd_sel_e         sel_a, sel_b;
  logic             ex_fwd_ok, ex_load, load_hit, stall_w, eq;
  logic [IDEX_W-1:0] idex_d, idex_q;
  logic             unused_op;

  assign rs        = id.d_inst[9:5];
  assign rt        = id.d_inst[4:0];
  assign rd        = id.d_inst[14:10];
  assign imm16     = id.d_inst[25:10];
  assign unused_op = ^id.d_inst[31:26];
  assign rn        = id.d_regrt ? rt : rd;
  assign imm       = id.d_sext ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};

  pipeid_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk      (clk),
    .clrn     (clrn),
    .ra_i     (rs),
    .rb_i     (rt),
    .w_we_i   (id.w_wreg),
    .w_rn_i   (id.w_rn),
    .w_data_i (id.w_data),
    .a_o      (rf_a),
    .b_o      (rf_b)
  );

  function automatic fwd_sel_e fwd_pick(input logic [4:0] r, input logic ex_ok,
                                        input logic [4:0] ex_rn, input logic m_wreg,
                                        input logic m_m2reg, input logic [4:0] m_rn);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (r != 5'd0) begin
      if (ex_ok && ex_rn == r) sel = FWD_EX;
      else if (m_wreg && m_rn == r) sel = m_m2reg ? FWD_MD : FWD_MA;
    end
    return sel;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] ex, input logic [XLEN-1:0] ma,
                                              input logic [XLEN-1:0] md);
    case (sel)
      FWD_EX:  return ex;
      FWD_MA:  return ma;
      FWD_MD:  return md;
      default: return rf;
    endcase
  endfunction

  // A load still in EX has no data yet, so only non-load EX results are forwarded.
  assign ex_fwd_ok = id.e_valid & id.e_wreg & ~id.e_m2reg;
  assign ex_load   = id.e_valid & id.e_wreg & id.e_m2reg & (id.e_rn != 5'd0);
  assign load_hit  = (id.d_uses_rs & (rs == id.e_rn)) | (id.d_uses_rt & (rt == id.e_rn)) |
                     ((id.d_br != BR_NONE) & ((rs == id.e_rn) | (rt == id.e_rn)));
  assign stall_w   = id.d_valid & ~id.d_flush & ex_load & load_hit;

  always_comb begin
    sel_a = fwd_pick(rs, ex_fwd_ok, id.e_rn, id.m_wreg, id.m_m2reg, id.m_rn);
    sel_b = fwd_pick(rt, ex_fwd_ok, id.e_rn, id.m_wreg, id.m_m2reg, id.m_rn);
    fwd_a = fwd_mux(sel_a, rf_a, id.e_alu, id.m_alu, id.m_mdata);
    fwd_b = fwd_mux(sel_b, rf_b, id.e_alu, id.m_alu, id.m_mdata);
  end

  assign eq          = (fwd_a == fwd_b);
  assign id.stall    = stall_w;
  assign id.bpc      = id.d_pc4 + (imm << 2);
  assign id.br_taken = id.d_valid & ~id.d_flush & ~stall_w &
                       (((id.d_br == BR_EQ) & eq) | ((id.d_br == BR_NE) & ~eq));

  always_comb begin
    idex_d = '0;
    if (id.d_valid && !id.d_flush && !stall_w)
      idex_d = {1'b1, id.d_wreg, id.d_m2reg, rn, id.d_ctl, fwd_a, fwd_b, imm, id.d_pc4};
  end

  always_ff @(posedge clk) begin
    if (!clrn) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign {id.e_valid, id.e_wreg, id.e_m2reg, id.e_rn, id.e_ctl,
          id.e_a, id.e_b, id.e_imm, id.e_pc4} = idex_q;
endmodule

// File: tb/tb_pipeid_stage.sv
// tb/tb_pipeid_stage.sv - vector table with an ID/EX scoreboard plus reset/stall corner sequences
module tb_pipeid_stage;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  pipeid_stage_if #(.XLEN(32), .CTLW(8)) bus ();
  pipeid_stage #(.XLEN(32), .NREG(16), .CTLW(8)) dut (.clk(clk), .clrn(clrn), .id(bus));

  typedef struct packed {
    logic        valid, wreg, m2reg;
    logic [4:0]  rn;
    logic [7:0]  ctl;
    logic [31:0] a, b, imm, pc4;
  } exp_t;

  typedef struct packed {
    logic        valid, flush, uses_rs, uses_rt, wreg, m2reg, regrt, sext;
    logic [1:0]  br;
    logic [4:0]  rs, rt;
    logic [15:0] imm16;
    logic [31:0] pc4;
    logic [7:0]  ctl;
    logic [31:0] e_alu;
    logic        m_wreg, m_m2reg;
    logic [4:0]  m_rn;
    logic [31:0] m_alu, m_mdata;
    logic        w_wreg;
    logic [4:0]  w_rn;
    logic [31:0] w_data;
    logic        x_stall, x_br;
    logic [31:0] x_bpc;
    exp_t        x;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   vidx = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic exp_t cap(input logic w, input logic m, input logic [4:0] rn, input logic [7:0] ctl,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [31:0] pc4);
    exp_t e;
    e = '{valid: 1'b1, wreg: w, m2reg: m, rn: rn, ctl: ctl, a: a, b: b, imm: imm, pc4: pc4};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", vidx, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.d_valid   = v.valid;
    bus.d_inst    = {6'd0, v.imm16, v.rs, v.rt};
    bus.d_pc4     = v.pc4;
    bus.d_ctl     = v.ctl;
    bus.d_uses_rs = v.uses_rs;
    bus.d_uses_rt = v.uses_rt;
    bus.d_wreg    = v.wreg;
    bus.d_m2reg   = v.m2reg;
    bus.d_regrt   = v.regrt;
    bus.d_sext    = v.sext;
    bus.d_br      = v.br;
    bus.d_flush   = v.flush;
    bus.e_alu     = v.e_alu;
    bus.m_wreg    = v.m_wreg;
    bus.m_m2reg   = v.m_m2reg;
    bus.m_rn      = v.m_rn;
    bus.m_alu     = v.m_alu;
    bus.m_mdata   = v.m_mdata;
    bus.w_wreg    = v.w_wreg;
    bus.w_rn      = v.w_rn;
    bus.w_data    = v.w_data;
  endtask

  task automatic check_idex(input exp_t x);
    chk("e_valid", 32'(bus.e_valid), 32'(x.valid));
    chk("e_wreg",  32'(bus.e_wreg),  32'(x.wreg));
    chk("e_m2reg", 32'(bus.e_m2reg), 32'(x.m2reg));
    chk("e_rn",    32'(bus.e_rn),    32'(x.rn));
    chk("e_ctl",   32'(bus.e_ctl),   32'(x.ctl));
    chk("e_a",     bus.e_a,   x.a);
    chk("e_b",     bus.e_b,   x.b);
    chk("e_imm",   bus.e_imm, x.imm);
    chk("e_pc4",   bus.e_pc4, x.pc4);
  endtask

  // Called at a negedge: combinational checks now, registered checks one edge later.
  task automatic apply(input vec_t v);
    drive(v);
    #1;
    chk("stall",    32'(bus.stall),    32'(v.x_stall));
    chk("br_taken", 32'(bus.br_taken), 32'(v.x_br));
    chk("bpc",      bus.bpc,           v.x_bpc);
    sb.push_back(v.x);
    @(negedge clk);
    check_idex(sb.pop_front());
    vidx++;
  endtask

  initial begin
    vec_t v;

    // WB preload while IF/ID is empty
    v = '0; v.w_wreg = 1; v.w_rn = 5'd1; v.w_data = 32'h7;          tbl.push_back(v);
    v = '0; v.w_wreg = 1; v.w_rn = 5'd4; v.w_data = 32'h100;        tbl.push_back(v);
    v = '0; v.w_wreg = 1; v.w_rn = 5'd6; v.w_data = 32'hAAAA_0000;  tbl.push_back(v);
    // plain RF read, rn = rd, zero-extended imm
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.wreg = 1; v.rs = 1; v.rt = 4;
    v.imm16 = 16'h0007; v.pc4 = 32'h40; v.ctl = 8'h5A; v.x_bpc = 32'h5C;
    v.x = cap(1, 0, 5'd7, 8'h5A, 32'h7, 32'h100, 32'h7, 32'h40);                 tbl.push_back(v);
    // EX forward wins over MEM on r7; rn = rt; sign-extended imm
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.regrt = 1; v.sext = 1; v.rs = 7; v.rt = 6;
    v.imm16 = 16'h8003; v.pc4 = 32'h80; v.ctl = 8'h3C; v.e_alu = 32'h999;
    v.m_wreg = 1; v.m_rn = 5'd7; v.m_alu = 32'h111; v.x_bpc = 32'hFFFE_008C;
    v.x = cap(0, 0, 5'd6, 8'h3C, 32'h999, 32'hAAAA_0000, 32'hFFFF_8003, 32'h80); tbl.push_back(v);
    // MEM load data forward on both operands; this instruction is itself a load to r1
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.wreg = 1; v.m2reg = 1; v.regrt = 1;
    v.rs = 1; v.rt = 1; v.pc4 = 32'h200; v.ctl = 8'hC3; v.m_wreg = 1; v.m_m2reg = 1; v.m_rn = 5'd1;
    v.m_alu = 32'h222; v.m_mdata = 32'h333; v.x_bpc = 32'h200;
    v.x = cap(1, 1, 5'd1, 8'hC3, 32'h333, 32'h333, 32'h0, 32'h200);             tbl.push_back(v);
    // load-use on rt: stall and bubble
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.wreg = 1; v.rs = 4; v.rt = 1;
    v.imm16 = 16'h0010; v.pc4 = 32'h300; v.ctl = 8'h11; v.x_stall = 1; v.x_bpc = 32'h340;
    v.x = '0;                                                                     tbl.push_back(v);
    // same instruction retried: load now in MEM, m_mdata forwarded
    v.m_wreg = 1; v.m_m2reg = 1; v.m_rn = 5'd1; v.m_mdata = 32'h1234; v.m_alu = 32'h5; v.x_stall = 0;
    v.x = cap(1, 0, 5'd16, 8'h11, 32'h100, 32'h1234, 32'h10, 32'h300);          tbl.push_back(v);
    // beq taken with EX forward on rt
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.br = 2'b01; v.rs = 1; v.rt = 16;
    v.imm16 = 16'h0004; v.pc4 = 32'h100; v.e_alu = 32'h7; v.x_br = 1; v.x_bpc = 32'h110;
    v.x = cap(0, 0, 5'd4, 8'h0, 32'h7, 32'h7, 32'h4, 32'h100);                  tbl.push_back(v);
    // bne not taken on r0 == r0, negative offset
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.br = 2'b10; v.sext = 1;
    v.imm16 = 16'hFFFF; v.pc4 = 32'h500; v.x_bpc = 32'h4FC;
    v.x = cap(0, 0, 5'd31, 8'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h500);         tbl.push_back(v);
    // bne taken
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.br = 2'b10; v.rs = 1; v.rt = 4;
    v.imm16 = 16'h0002; v.pc4 = 32'h20; v.x_br = 1; v.x_bpc = 32'h28;
    v.x = cap(0, 0, 5'd2, 8'h0, 32'h7, 32'h100, 32'h2, 32'h20);                 tbl.push_back(v);
    // WB write-through bypass on r3
    v = '0; v.valid = 1; v.uses_rs = 1; v.rs = 3; v.w_wreg = 1; v.w_rn = 5'd3; v.w_data = 32'h55;
    v.x = cap(0, 0, 5'd0, 8'h0, 32'h55, 32'h0, 32'h0, 32'h0);                   tbl.push_back(v);
    // r3 from the array; write to r0 must not show on rt=0
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.rs = 3; v.pc4 = 32'h44;
    v.w_wreg = 1; v.w_rn = 5'd0; v.w_data = 32'hDEAD; v.x_bpc = 32'h44;
    v.x = cap(0, 0, 5'd0, 8'h0, 32'h55, 32'h0, 32'h0, 32'h44);                  tbl.push_back(v);
    // load to r9, then flushed consumer: no stall, no branch, bubble
    v = '0; v.valid = 1; v.uses_rs = 1; v.wreg = 1; v.m2reg = 1; v.regrt = 1; v.rt = 9;
    v.pc4 = 32'h600; v.ctl = 8'h81; v.x_bpc = 32'h600;
    v.x = cap(1, 1, 5'd9, 8'h81, 32'h0, 32'h0, 32'h0, 32'h600);                 tbl.push_back(v);
    v = '0; v.valid = 1; v.flush = 1; v.uses_rs = 1; v.br = 2'b01; v.rs = 9; v.rt = 9;
    v.imm16 = 16'h0001; v.pc4 = 32'h700; v.x_bpc = 32'h704; v.x = '0;            tbl.push_back(v);
    // write to r20 (beyond NREG=16) is dropped, read returns 0
    v = '0; v.w_wreg = 1; v.w_rn = 5'd20; v.w_data = 32'h77;                     tbl.push_back(v);
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.rs = 20; v.pc4 = 32'h800; v.x_bpc = 32'h800;
    v.x = cap(0, 0, 5'd0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h800);                  tbl.push_back(v);
    // load to r5, then a branch reading r5 stalls even without uses flags
    v = '0; v.valid = 1; v.uses_rs = 1; v.wreg = 1; v.m2reg = 1; v.regrt = 1; v.rt = 5;
    v.pc4 = 32'h600; v.ctl = 8'h81; v.x_bpc = 32'h600;
    v.x = cap(1, 1, 5'd5, 8'h81, 32'h0, 32'h0, 32'h0, 32'h600);                 tbl.push_back(v);
    v = '0; v.valid = 1; v.br = 2'b01; v.rs = 5; v.pc4 = 32'h900; v.x_stall = 1; v.x_bpc = 32'h900;
    v.x = '0;                                                                     tbl.push_back(v);
    // reserved branch type never redirects
    v = '0; v.valid = 1; v.br = 2'b11; v.imm16 = 16'h0003; v.pc4 = 32'hA00; v.x_bpc = 32'hA0C;
    v.x = cap(0, 0, 5'd3, 8'h0, 32'h0, 32'h0, 32'h3, 32'hA00);                  tbl.push_back(v);

    // reset state
    drive('0);
    repeat (2) @(negedge clk);
    chk("rst stall",    32'(bus.stall),    32'h0);
    chk("rst br_taken", 32'(bus.br_taken), 32'h0);
    check_idex('0);
    clrn = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // reset in the middle of a load-use stall
    v = '0; v.valid = 1; v.uses_rs = 1; v.wreg = 1; v.m2reg = 1; v.regrt = 1; v.rt = 5;
    v.pc4 = 32'h600; v.ctl = 8'h81; v.x_bpc = 32'h600;
    v.x = cap(1, 1, 5'd5, 8'h81, 32'h0, 32'h0, 32'h0, 32'h600);
    apply(v);
    v = '0; v.valid = 1; v.uses_rt = 1; v.wreg = 1; v.rt = 5; v.pc4 = 32'hB00;
    drive(v);
    #1;
    chk("pre-reset stall", 32'(bus.stall), 32'h1);
    clrn = 1'b0;
    @(negedge clk);
    chk("reset stall", 32'(bus.stall), 32'h0);
    check_idex('0);
    clrn = 1'b1;
    vidx++;
    // register file was cleared by the reset
    v = '0; v.valid = 1; v.uses_rs = 1; v.uses_rt = 1; v.rs = 1; v.rt = 4; v.pc4 = 32'hC00;
    v.x_bpc = 32'hC00; v.x = cap(0, 0, 5'd0, 8'h0, 32'h0, 32'h0, 32'h0, 32'hC00);
    apply(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeid_stage.md
# pipeid_stage

Parameterised instruction-decode stage for the pipelined CPU. It reads the register file and forwards operands from EX, MEM and WB. It detects load-use hazards and raises a stall, resolves beq/bne inside ID, and owns the ID/EX pipeline register, which supports bubble and flush. It sits between the IF/ID register and the EX stage, and takes its control word from the separate decoder.

## Interface
- XLEN, 32, datapath width; must be 32 or more.
- NREG, 32, number of architectural registers; range 2..32.
- CTLW, 8, width of the opaque control bundle passed through to EX.
- clk  in  1  clock; everything is updated on the rising edge.
- clrn  in  1  synchronous active-low reset.
- d_valid  in  1  the IF/ID slot holds a real instruction.
- d_inst  in  32  instruction. Fields:
  - op = inst[31:26]
  - rs = inst[9:5]
  - rt = inst[4:0]
  - rd = inst[14:10]
  - imm16 = inst[25:10]
- d_pc4  in  XLEN  PC+4 of the instruction.
- d_ctl  in  CTLW  decoded EX/MEM control; passed through unchanged.
- d_uses_rs, d_uses_rt  in  1 each  the instruction reads rs / rt.
- d_wreg, d_m2reg, d_regrt, d_sext  in  1 each  writes a register / is a load / destination is rt / immediate is sign-extended.
- d_br  in  2  branch type: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- d_flush  in  1  squash the ID instruction (exception or redirect from a later stage).
- e_alu  in  XLEN  EX-stage ALU result, combinational.
- m_wreg, m_m2reg  in  1 each  MEM-stage instruction writes a register / is a load.
- m_rn  in  5  MEM-stage destination register.
- m_alu, m_mdata  in  XLEN each  MEM-stage ALU result / load data.
- w_wreg  in  1  WB-stage write enable.
- w_rn  in  5  WB-stage destination register.
- w_data  in  XLEN  WB-stage write data.
- stall  out  1  hold PC and IF/ID this cycle.
- br_taken  out  1  redirect the PC to bpc and squash IF/ID.
- bpc  out  XLEN  branch target.
- e_valid, e_wreg, e_m2reg  out  1 each  ID/EX register fields.
- e_rn  out  5  ID/EX destination register.
- e_ctl  out  CTLW  ID/EX control bundle.
- e_a, e_b, e_imm, e_pc4  out  XLEN each  ID/EX operands, immediate and PC+4.

## Operation
- **Register file**
  - NREG×XLEN; r0 always reads 0.
  - Indices ≥ NREG read 0, and writes to them are ignored.
  - Write happens on the rising edge when w_wreg=1 and w_rn≠0.
  - A same-cycle read of w_rn returns w_data (write-through bypass).
- **Operand forwarding** (rs and rt each; first match wins):
  - EX: e_valid & e_wreg & ~e_m2reg & e_rn==r & r≠0 → e_alu.
  - MEM: m_wreg & m_rn==r & r≠0 → m_alu, or m_mdata when m_m2reg=1.
  - Otherwise the register-file value.
- **Load-use stall**
  - stall = d_valid & ~d_flush & e_valid & e_wreg & e_m2reg & e_rn≠0, AND a read hit on that register:
    - d_uses_rs & rs==e_rn, or
    - d_uses_rt & rt==e_rn, or
    - d_br≠00 & (rs==e_rn | rt==e_rn).
- **Immediate**: imm16 is sign-extended when d_sext=1 and zero-extended otherwise, giving e_imm width XLEN.
- **Branch**
  - Operands equal: eq = (fwd_a == fwd_b).
  - br_taken = d_valid & ~d_flush & ~stall & ((d_br==01 & eq) | (d_br==10 & ~eq)).
  - bpc = d_pc4 + (imm<<2), taken mod 2^XLEN. It is always computed, even when no branch is taken.
- **Destination**: rn = d_regrt ? rt : rd.
- **ID/EX register update** each edge, in priority order:
  1. clrn=0 → all e_* outputs = 0.
  2. d_flush | stall | ~d_valid → bubble: e_valid=e_wreg=e_m2reg=0; e_ctl=0; data fields don't-care (implementation zeroes them).
  3. Otherwise → capture fwd_a, fwd_b, imm, rn, the control signals and d_pc4; e_valid=1.
- **Simultaneous events**
  - Flush overrides stall: the instruction is discarded and stall=0.
  - A WB write to a register also read in ID returns the new value via the bypass.
  - Reset in the middle of a stall clears the ID/EX register; stall drops as soon as e_valid=0.

## Timing
- Latency is 1 cycle from ID input to the e_* outputs.
- stall, br_taken and bpc are combinational in the same cycle.
- A load-use hazard costs exactly 1 bubble. The next cycle the load is in MEM and m_mdata is forwarded.
- A taken branch costs 1 IF slot; there is no delay slot. Upstream squashes IF/ID.
- During reset and the first cycle after it: all e_* = 0, stall = 0, br_taken = 0.

## Structure
- The shared package holds:
  - branch-type constants BR_NONE, BR_EQ, BR_NE;
  - forward-select enum FWD_RF, FWD_EX, FWD_MA, FWD_MD;
  - a function computing the ID/EX register-field width.
- One sub-module, pipeid_regfile, parameterised by XLEN and NREG, with the write-through bypass and synchronous reset clear.

## Test plan
- **WB bypass**: w_wreg=1, w_rn=3, w_data=0x55, with the ID instruction reading rs=3 → next cycle e_a=0x55.
- **Load-use**: EX holds a load to r5; ID add uses rt=5 → stall=1 for one cycle, then a bubble in e_*; the next cycle m_mdata=0x1234 is forwarded and e_b=0x1234.
- **beq with EX forward**: EX ALU writes r2 with e_alu=7, RF r1=7, d_br=01, rs=1, rt=2, imm16=0x0004, d_pc4=0x100 → br_taken=1, bpc=0x110.
- **bne not taken**: rs=rt=0, imm16=0xFFFF with sext → br_taken=0, bpc=d_pc4-4.
- **Flush during stall**: load-use condition with d_flush=1 → stall=0, e_valid=0 next cycle.
- **Reset**: clrn=0 while e_valid=1 → next edge all e_*=0; a read of r0 after any write to r0 returns 0.
